// File: rtl/xlib_arb_pkg.sv
// ----------------------------------------------------------------------------
// xlib_arb_pkg : shared types and round-robin pick helper for xlib_op_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package xlib_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAX = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // ptr < nreq and k < nreq, so a single conditional subtract replaces the modulo
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int unsigned        ptr,
                                    input int unsigned        nreq);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = ptr + k;
      if (j >= nreq) j = j - nreq;
      if (!p.found && (k < nreq) && valid[j[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xlib_op_arbiter_if.sv
// ----------------------------------------------------------------------------
// xlib_op_arbiter_if : request and response channels of the shared-ALU arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface xlib_op_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_flag;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
  );

endinterface

`default_nettype wire

// File: rtl/xlib_alu_unit.sv
// ----------------------------------------------------------------------------
// xlib_alu_unit : LAT-cycle add/sub/mul/max datapath with start and done pulses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xlib_alu_unit
  import xlib_arb_pkg::*;
#(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] data,
  output logic         flag
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  logic           busy;
  logic [CW-1:0]  cnt;
  op_e            op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(LAT - 1);
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  // Result is valid combinationally in the final count cycle; the owner registers it
  assign done = busy && (cnt == '0);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

  always_comb begin
    data = '0;
    flag = 1'b0;
    case (op_q)
      OP_ADD: begin data = sum[W-1:0];  flag = sum[W];  end
      OP_SUB: begin data = diff[W-1:0]; flag = diff[W]; end
      OP_MUL: begin data = prod[W-1:0]; flag = |prod[2*W-1:W]; end
      OP_MAX: begin
        data = (a_q >= b_q) ? a_q : b_q;
        flag = (a_q >= b_q);
      end
      default: begin data = '0; flag = 1'b0; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/xlib_op_arbiter.sv
// ----------------------------------------------------------------------------
// xlib_op_arbiter : round-robin sharing of one multi-cycle ALU among NREQ requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xlib_op_arbiter
  import xlib_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  xlib_op_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state;
  state_e          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  winner;
  pick_t           pick;
  logic            start;
  logic            alu_done;
  logic [W-1:0]    alu_data;
  logic            alu_flag;
  op_e             win_op;
  logic [W-1:0]    win_a;
  logic [W-1:0]    win_b;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_flag;
  logic            unused_pick_hi;

  assign pick           = rr_pick(MAX_REQ'(bus.req_valid), 32'(ptr), NREQ);
  assign winner         = pick.idx[IDW-1:0];
  assign unused_pick_hi = ^pick.idx;

  assign win_op = op_e'(bus.req_op[2*winner +: 2]);
  assign win_a  = bus.req_a[W*winner +: W];
  assign win_b  = bus.req_b[W*winner +: W];

  // Grant is only offered in IDLE and is held off while reset is asserted
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick.found && !rst) begin
          req_ready[winner] = 1'b1;
          start             = 1'b1;
          state_nxt         = ST_EXEC;
        end
      end
      ST_EXEC: if (alu_done)      state_nxt = ST_DONE;
      ST_DONE: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        id_q <= winner;
        ptr  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
      if ((state == ST_EXEC) && alu_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= alu_data;
        rsp_flag  <= alu_flag;
      end else if ((state == ST_DONE) && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  xlib_alu_unit #(
    .W   (W),
    .LAT (LAT)
  ) u_alu (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (win_op),
    .a     (win_a),
    .b     (win_b),
    .done  (alu_done),
    .data  (alu_data),
    .flag  (alu_flag)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_flag  = rsp_flag;

endmodule

`default_nettype wire

// File: tb/tb_xlib_op_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xlib_op_arbiter : directed and randomized checks of xlib_op_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_xlib_op_arbiter;
  import xlib_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xlib_op_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  xlib_op_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;
  int acc_gap  = 0;
  int mptr     = 0;

  logic [NREQ-1:0] valid;
  logic [1:0]      op_r [NREQ];
  logic [W-1:0]    a_r  [NREQ];
  logic [W-1:0]    b_r  [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[2*i +: 2] = op_r[i];
      bus.req_a[W*i +: W]  = a_r[i];
      bus.req_b[W*i +: W]  = b_r[i];
    end
    bus.req_valid = valid;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  task automatic new_req(input int i);
    valid[i] = 1'b1;
    op_r[i]  = 2'($urandom_range(0, 3));
    a_r[i]   = rand_operand();
    b_r[i]   = rand_operand();
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b);
    valid[i] = 1'b1;
    op_r[i]  = 2'(op);
    a_r[i]   = W'(a);
    b_r[i]   = W'(b);
  endtask

  // Winner: first asserted requester scanning ptr, ptr+1, ... wrapping
  function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // {flag, data} from plain integer arithmetic
  function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int ia, ib, r;
    bit f;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    begin r = ia + ib; f = (r >= (1 << W)); end
      2'd1:    begin r = ia - ib; f = (ia < ib); end
      2'd2:    begin r = ia * ib; f = (r >= (1 << W)); end
      default: begin r = (ia >= ib) ? ia : ib; f = (ia >= ib); end
    endcase
    return {f, r[W-1:0]};
  endfunction

  // One arbitration round from an IDLE cycle: grant, execute, response, release
  task automatic serve_one(input bit keep, input int hold, output int wid,
                           output logic [W:0] got);
    logic [W:0] exp;
    int w;
    got = '0;
    drive();
    #1;
    w   = ref_pick(valid, mptr);
    wid = w;
    check("idle_req_ready", 32'(bus.req_ready), (w < 0) ? 0 : (1 << w));
    check("idle_rsp_valid", 32'(bus.rsp_valid), 0);
    if (w < 0) begin
      tick();
      return;
    end
    exp = ref_op(op_r[w], a_r[w], b_r[w]);
    tick();
    acc_gap  = cyc - last_acc;
    last_acc = cyc;
    mptr     = (w + 1) % NREQ;
    if (keep) new_req(w);
    else      valid[w] = 1'b0;
    drive();
    bus.rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < LAT; k++) begin
      check("exec_req_ready", 32'(bus.req_ready), 0);
      check("exec_rsp_valid", 32'(bus.rsp_valid), 0);
      tick();
    end
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_id", 32'(bus.rsp_id), w);
    check("rsp_data", 32'(bus.rsp_data), 32'(exp[W-1:0]));
    check("rsp_flag", 32'(bus.rsp_flag), 32'(exp[W]));
    got = {bus.rsp_flag, bus.rsp_data};
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      check("hold_rsp", 32'({bus.rsp_id, bus.rsp_flag, bus.rsp_data}),
            32'({2'(w), exp[W], exp[W-1:0]}));
      check("hold_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_release", 32'(bus.rsp_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [W:0] got;
    int t2_op [4] = '{1, 2, 3, 2};
    int t2_a  [4] = '{5, 16, 7, 3};
    int t2_b  [4] = '{9, 17, 3, 4};
    int t2_d  [4] = '{252, 16, 7, 12};
    int t2_f  [4] = '{1, 1, 1, 0};
    int seq3  [5] = '{0, 1, 2, 3, 0};

    // Reset values, with every requester asserting valid
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    valid = '0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    drive();
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_flag", 32'(bus.rsp_flag), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    check("rst_hold_req_ready", 32'(bus.req_ready), 0);
    rst   = 1'b0;
    mptr  = 0;
    valid = '0;

    // Single ADD that wraps with carry
    set_req(0, 0, 200, 100);
    serve_one(1'b0, 0, w, got);
    check("t1_id", 32'(w), 0);
    check("t1_data", 32'(got[W-1:0]), 44);
    check("t1_flag", 32'(got[W]), 1);

    // Each op kind from a different requester
    for (int k = 0; k < 4; k++) begin
      set_req(k, t2_op[k], t2_a[k], t2_b[k]);
      serve_one(1'b0, 0, w, got);
      check("t2_data", 32'(got[W-1:0]), t2_d[k]);
      check("t2_flag", 32'(got[W]), t2_f[k]);
    end

    // All requesters valid continuously: strict rotation, LAT+2 spacing
    do_reset();
    for (int i = 0; i < NREQ; i++) new_req(i);
    for (int n = 0; n < 5; n++) begin
      serve_one(1'b1, 0, w, got);
      check("t3_id", 32'(w), seq3[n]);
      if (n > 0) check("t3_spacing", 32'(acc_gap), LAT + 2);
    end

    // Backpressure for 10 cycles in DONE with all requesters pending
    serve_one(1'b1, 10, w, got);
    serve_one(1'b1, 0, w, got);
    check("t4_after_release_spacing", 32'(acc_gap), LAT + 2 + 10);

    // Reset mid-EXEC with cnt=1 while REQ2 waits
    do_reset();
    valid = '0;
    drive();
    set_req(0, 2, 9, 9);
    drive();
    #1;
    check("t5_grant0", 32'(bus.req_ready), 1);
    tick();
    valid[0] = 1'b0;
    set_req(2, 1, 40, 2);
    drive();
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t5_rst_req_ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    check("t5_rst_rsp_valid_late", 32'(bus.rsp_valid), 0);
    rst  = 1'b0;
    mptr = 0;
    serve_one(1'b0, 0, w, got);
    check("t5_id", 32'(w), 2);

    // ptr=3 with only REQ1 and REQ3 valid: wrap-around order 3 then 1
    set_req(1, 0, 1, 1);
    set_req(3, 3, 2, 5);
    serve_one(1'b0, 0, w, got);
    check("t6_first", 32'(w), 3);
    serve_one(1'b0, 0, w, got);
    check("t6_second", 32'(w), 1);

    // Reset while a response is pending in DONE: cleared at once, ptr back to 0
    set_req(1, 0, 3, 4);
    drive();
    tick();
    valid[1] = 1'b0;
    drive();
    repeat (LAT) tick();
    check("t7_pre_rst_valid", 32'(bus.rsp_valid), 1);
    rst = 1'b1;
    #1;
    check("t7_async_valid", 32'(bus.rsp_valid), 0);
    check("t7_async_data", 32'(bus.rsp_data), 0);
    check("t7_async_id", 32'(bus.rsp_id), 0);
    tick();
    rst  = 1'b0;
    mptr = 0;
    set_req(0, 0, 10, 20);
    set_req(3, 0, 30, 40);
    serve_one(1'b0, 0, w, got);
    check("t7_ptr_reset", 32'(w), 0);
    serve_one(1'b0, 0, w, got);
    check("t7_next", 32'(w), 3);

    // Randomized traffic against the reference model
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (valid[i]) begin
          if ($urandom_range(0, 7) == 0) valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          new_req(i);
        end
      end
      serve_one(1'($urandom_range(0, 1)), $urandom_range(0, 3), w, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
